uart_tx_mmio: RTL and testbench



---
 rtl/uart_tx_mmio_if.sv | 25 ++
 rtl/uart_tx_mmio.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_mmio_if.sv
// Data-memory side bus between the core's load/store port and the UART
// transmitter. The core (or a bench) drives the master side; the UART is the slave.
interface uart_tx_mmio_if;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;

    modport master (
        output addr,
        output wen,
        output wdata,
        input  rdata,
        input  hit
    );

    modport slave (
        input  addr,
        input  wen,
        input  wdata,
        output rdata,
        output hit
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter.
// Stores to TXDATA fill a small byte FIFO. A baud-rate FSM drains the FIFO
// one frame at a time onto tx. STATUS and DIVISOR are readable with one cycle
// of latency. hit lets the interconnect pick this block's read data over RAM.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_mmio_if.slave bus,
    output logic          tx
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // Register-window decode
    logic       wr_en;
    logic [1:0] reg_sel;
    logic       push_req;
    logic       push;
    logic       pop;

    // FIFO storage and bookkeeping
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_full, fifo_empty;

    // Control/status registers
    logic        ovf_q;
    logic [15:0] div_q;
    logic [31:0] rdata_q, rd_val;
    logic [31:0] status;
    logic [3:0]  count4;

    // Transmit FSM
    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] divact_q, divact_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic        tx_q, tx_d;
    logic        baud_end;
    logic        busy;

    // Bus bits that carry no meaning for this block
    logic unused_bits;
    assign unused_bits = ^{bus.wdata[31:16], bus.addr[1:0]};

    assign bus.hit  = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign wr_en    = bus.wen & bus.hit;
    assign reg_sel  = bus.addr[3:2];
    assign push_req = wr_en && (reg_sel == 2'd0);

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // A store into a full FIFO is dropped; overflow records it.
    assign push       = push_req && !fifo_full;
    assign count_d    = (push && !pop) ? count_q + CNT_W'(1) :
                        (!push && pop) ? count_q - CNT_W'(1) : count_q;

    assign busy     = (state_q != ST_IDLE);
    assign baud_end = (baud_q == divact_q - 16'd1);
    assign count4   = 4'(count_q);
    assign status   = {20'd0, count4, 4'd0, ovf_q, busy, fifo_empty, fifo_full};

    assign bus.rdata = rdata_q;
    assign tx        = tx_q;

    // FIFO payload write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.wdata[7:0];
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Sticky overflow flag (write-one-to-clear) and the programmable bit period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            div_q <= DIV_RESET;
        end else begin
            if (push_req && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (wr_en && (reg_sel == 2'd1) && bus.wdata[3]) begin
                ovf_q <= 1'b0;
            end
            if (wr_en && (reg_sel == 2'd2)) begin
                div_q <= (bus.wdata[15:0] == 16'd0) ? 16'd1 : bus.wdata[15:0];
            end
        end
    end

    // Read mux uses pre-edge state so a same-cycle write is not yet visible
    always_comb begin
        rd_val = '0;
        if (bus.hit) begin
            case (reg_sel)
                2'd1:    rd_val = status;
                2'd2:    rd_val = {16'd0, div_q};
                default: rd_val = '0;
            endcase
        end
    end

    // Registered read data, one cycle after the address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rd_val;
    end

    // Transmit FSM state and the registered serial line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            divact_q <= 16'd1;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            divact_q <= divact_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
        end
    end

    // Next-state logic; tx is derived from the next state so the line changes on the transition edge
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        divact_d = divact_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_d  = fifo_mem[rd_ptr_q];
                    divact_d = div_q;   // frame keeps this period even if DIVISOR changes
                    baud_d   = '0;
                    bit_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tx_d = 1'b1;
        if (state_d == ST_START)     tx_d = 1'b0;
        else if (state_d == ST_DATA) tx_d = shift_d[0];
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register access, frame timing and reset.
module tb_uart_tx_mmio;
    localparam logic [31:0] A_TX = 32'h1000_0000;
    localparam logic [31:0] A_ST = 32'h1000_0004;
    localparam logic [31:0] A_DV = 32'h1000_0008;
    localparam logic [31:0] A_RS = 32'h1000_000C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
    int   checks = 0;
    int   errors = 0;

    uart_tx_mmio_if bus ();

    uart_tx_mmio dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr  = a;
        bus.wdata = d;
        bus.wen   = 1'b1;
        @(negedge clk);
        bus.wen   = 1'b0;
        bus.addr  = 32'h0;
        $display("wr addr=%h data=%h", a, d);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.wen  = 1'b0;
        @(negedge clk);
        d = bus.rdata;
        bus.addr = 32'h0;
        $display("rd addr=%h data=%h", a, d);
    endtask

    // Called at the negedge before the edge that starts the frame. Checks every
    // clock of all ten bit slots, then the single idle cycle that follows.
    task automatic check_frame(input string tag, input logic [7:0] b, input int d);
        logic [9:0]  bits;
        logic [31:0] got;
        logic [31:0] exp;
        bits = {1'b1, b, 1'b0};
        for (int s = 0; s < 10; s++) begin
            got = '0;
            exp = '0;
            for (int c = 0; c < d; c++) begin
                @(negedge clk);
                got[c] = tx;
                exp[c] = bits[s];
            end
            check_val($sformatf("%s.slot%0d", tag, s), got, exp);
        end
        @(negedge clk);
        check_val({tag, ".idle"}, {31'd0, tx}, 32'd1);
        $display("frame %s byte=%h div=%0d", tag, b, d);
    endtask

    logic [31:0] rd;
    int          lows;

    initial begin
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        bus.wen   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_val("rst_tx", {31'd0, tx}, 32'd1);
        check_val("rst_rdata", bus.rdata, 32'd0);
        bus_read(A_ST, rd);  check_val("rst_status", rd, 32'h0000_0002);
        bus_read(A_DV, rd);  check_val("rst_div", rd, 32'd434);

        // Single frame at D=4
        bus_write(A_DV, 32'd4);
        bus_write(A_TX, 32'h55);
        check_frame("f55", 8'h55, 4);
        bus_read(A_ST, rd);  check_val("f55_status", rd, 32'h0000_0002);

        // Overflow: D=1, ten consecutive stores; 0x0A finds the FIFO full
        bus_write(A_DV, 32'd1);
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    bus.addr  = A_TX;
                    bus.wdata = 32'(i + 1);
                    bus.wen   = 1'b1;
                end
                @(negedge clk);
                bus.wen  = 1'b0;
                bus.addr = A_ST;
                @(negedge clk);
                check_val("ovf_status", bus.rdata, 32'h0000_080D);
                bus.addr  = A_ST;
                bus.wdata = 32'h8;
                bus.wen   = 1'b1;
                @(negedge clk);
                bus.wen = 1'b0;
                @(negedge clk);
                check_val("ovf_clear", bus.rdata & 32'h8, 32'h0);
                check_val("ovf_count", (bus.rdata >> 8) & 32'hF, 32'd8);
                bus.addr = 32'h0;
                $display("burst 0x01..0x0A pushed");
            end
            begin
                @(negedge clk);
                @(negedge clk);
                for (int i = 1; i <= 9; i++) begin
                    check_frame($sformatf("burst%0d", i), 8'(i), 1);
                end
            end
        join
        bus_read(A_ST, rd);  check_val("burst_status", rd, 32'h0000_0002);

        // Push aligned with pop: count holds at 1, both bytes sent in order
        fork
            begin
                @(negedge clk);
                bus.addr = A_TX; bus.wdata = 32'hA5; bus.wen = 1'b1;
                @(negedge clk);
                bus.wdata = 32'h3C;
                @(negedge clk);
                bus.wen = 1'b0; bus.addr = A_ST;
                @(negedge clk);
                check_val("pushpop_status", bus.rdata, 32'h0000_0104);
                bus.addr = 32'h0;
                $display("push/pop same edge A5,3C");
            end
            begin
                @(negedge clk);
                @(negedge clk);
                check_frame("pp_a5", 8'hA5, 1);
                check_frame("pp_3c", 8'h3C, 1);
            end
        join

        // Divisor of zero is stored as one
        bus_write(A_DV, 32'd0);
        bus_read(A_DV, rd);  check_val("div_zero", rd, 32'd1);

        // DIVISOR change mid-frame applies to the next frame only
        bus_write(A_DV, 32'd2);
        fork
            begin
                @(negedge clk);
                bus.addr = A_TX; bus.wdata = 32'hC3; bus.wen = 1'b1;
                @(negedge clk);
                bus.addr = A_DV; bus.wdata = 32'd8;
                @(negedge clk);
                bus.addr = A_TX; bus.wdata = 32'h81;
                @(negedge clk);
                bus.wen = 1'b0; bus.addr = A_ST;
                @(negedge clk);
                check_val("mid_status", bus.rdata, 32'h0000_0104);
                bus.addr = 32'h0;
                $display("divisor 2->8 mid-frame");
            end
            begin
                @(negedge clk);
                @(negedge clk);
                check_frame("d2_c3", 8'hC3, 2);
                check_frame("d8_81", 8'h81, 8);
            end
        join
        bus_read(A_DV, rd);  check_val("div_eight", rd, 32'd8);

        // Asynchronous reset during the data bits of a frame
        bus_write(A_DV, 32'd4);
        bus_write(A_TX, 32'hF0);
        bus_write(A_TX, 32'h0F);
        repeat (4) @(negedge clk);
        check_val("pre_rst_tx", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_tx", {31'd0, tx}, 32'd1);
        check_val("async_rst_rdata", bus.rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_read(A_ST, rd);  check_val("post_rst_status", rd, 32'h0000_0002);
        bus_read(A_DV, rd);  check_val("post_rst_div", rd, 32'd434);
        lows = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        check_val("no_residual_frame", 32'(lows), 32'd0);

        // Address decode and reads of write-only / reserved offsets
        @(negedge clk);
        bus.addr = 32'h1000_0010; #1;
        check_val("hit_above", {31'd0, bus.hit}, 32'd0);
        bus.addr = 32'h0000_0004; #1;
        check_val("hit_low", {31'd0, bus.hit}, 32'd0);
        bus.addr = A_ST; #1;
        check_val("hit_status", {31'd0, bus.hit}, 32'd1);
        bus_read(32'h1000_0010, rd); check_val("miss_rdata_a", rd, 32'd0);
        bus_read(32'h0000_0004, rd); check_val("miss_rdata_b", rd, 32'd0);
        bus_read(A_RS, rd);          check_val("reserved_rdata", rd, 32'd0);
        bus_read(A_TX, rd);          check_val("txdata_rdata", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
